// File: rtl/pixel_byte_packer.sv
// Packs a byte stream into 1- or 3-byte pixels, one frame mode latched per frame,
// with a fixed ready-low gap after every emitted pixel and a per-frame pixel count.
module pixel_byte_packer #(
  parameter int MAX_PIXEL_BITS = 24,
  parameter int PX_GAP         = 2,
  parameter int FRAME_PIXELS   = 4096
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [1:0]                select_i,
  input  logic [7:0]                byte_i,
  input  logic                      byte_valid_i,
  output logic                      byte_ready_o,
  output logic [MAX_PIXEL_BITS-1:0] out_pixel_o,
  output logic                      px_rdy_o,
  output logic                      start_sobel_o,
  output logic                      frame_done_o
);

  localparam int PCW = $clog2(FRAME_PIXELS + 1);
  localparam int GW  = (PX_GAP > 1) ? $clog2(PX_GAP) : 1;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, GAP} state_t;

  state_t           state, state_nxt;
  logic [1:0]       idx;
  logic [1:0]       mode;
  logic [7:0]       b0, b1;
  logic [PCW-1:0]   pix_cnt;
  logic [GW-1:0]    gap_cnt;
  logic [1:0]       mode_now;
  logic             one_byte;
  logic             accept;
  logic             last_byte;
  logic             frame_last;
  logic [23:0]      pix;

  // In IDLE the incoming select_i defines the frame; afterwards the latched copy rules.
  assign mode_now   = (state == IDLE) ? select_i : mode;
  assign one_byte   = (mode_now == 2'b01);
  assign accept     = byte_valid_i && byte_ready_o;
  assign last_byte  = one_byte || (idx == 2'd2);
  assign frame_last = (pix_cnt == PCW'(FRAME_PIXELS - 1));
  assign pix        = one_byte ? {16'h0000, byte_i} : {b0, b1, byte_i};

  always_comb begin
    state_nxt    = state;
    byte_ready_o = 1'b0;
    px_rdy_o     = 1'b0;
    frame_done_o = 1'b0;
    case (state)
      IDLE: begin
        byte_ready_o = 1'b1;
        if (accept) state_nxt = last_byte ? EMIT : COLLECT;
      end
      COLLECT: begin
        byte_ready_o = 1'b1;
        if (accept && last_byte) state_nxt = EMIT;
      end
      EMIT: begin
        px_rdy_o     = 1'b1;
        frame_done_o = frame_last;
        if (PX_GAP == 0) state_nxt = frame_last ? IDLE : COLLECT;
        else             state_nxt = GAP;
      end
      GAP: begin
        // A cleared pixel counter after an emit means the frame just finished.
        if (gap_cnt == '0) state_nxt = (pix_cnt == '0) ? IDLE : COLLECT;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      idx           <= 2'd0;
      mode          <= 2'b00;
      pix_cnt       <= '0;
      gap_cnt       <= '0;
      start_sobel_o <= 1'b0;
      out_pixel_o   <= '0;
    end else begin
      state         <= state_nxt;
      start_sobel_o <= (state == IDLE) && accept && !select_i[1];
      if (accept) begin
        if (state == IDLE) mode <= select_i;
        idx <= last_byte ? 2'd0 : idx + 2'd1;
        if (last_byte) out_pixel_o <= MAX_PIXEL_BITS'(pix);
      end
      if (state == EMIT) begin
        pix_cnt <= frame_last ? '0 : pix_cnt + 1'b1;
        gap_cnt <= GW'(PX_GAP - 1);
      end else if (state == GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && !last_byte) begin
      if (idx == 2'd0) b0 <= byte_i;
      else             b1 <= byte_i;
    end
  end

endmodule

// File: tb/tb_pixel_byte_packer.sv
// Bench for pixel_byte_packer: event-level reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_pixel_byte_packer;
  localparam int PX_GAP = 2;
  localparam int FP     = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [7:0]  data = 8'h00;
  logic        ready, px_rdy, sobel, done;
  logic [23:0] out_pixel;

  always #5 clk = ~clk;

  pixel_byte_packer #(.MAX_PIXEL_BITS(24), .PX_GAP(PX_GAP), .FRAME_PIXELS(FP)) dut (
    .clk_i(clk), .reset_i(reset), .select_i(sel), .byte_i(data),
    .byte_valid_i(valid), .byte_ready_o(ready), .out_pixel_o(out_pixel),
    .px_rdy_o(px_rdy), .start_sobel_o(sobel), .frame_done_o(done));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: bytes accepted while not busy; a pixel completes after 1 or 3 bytes,
  // appears the next cycle, and blocks input for 1+PX_GAP cycles.
  int          busy = 0;
  bit          in_frame = 0;
  logic [1:0]  m_mode = 2'b00;
  logic [7:0]  mb [3];
  int          nb = 0;
  int          pcnt = 0;
  bit          m_ready = 1, m_px = 0, m_sobel = 0, m_done = 0, acc = 0;
  logic [23:0] m_pixel = 24'h0;
  bit          started = 0;

  always @(posedge clk) begin
    started = 1;
    m_px = 0; m_sobel = 0; m_done = 0;
    if (reset) begin
      busy = 0; in_frame = 0; nb = 0; pcnt = 0; m_pixel = 24'h0;
    end else begin
      acc = valid && (busy == 0);
      if (busy > 0) busy--;
      if (acc) begin
        if (!in_frame) begin
          in_frame = 1;
          m_mode   = sel;
          m_sobel  = (sel == 2'b00) || (sel == 2'b01);
        end
        mb[nb] = data;
        nb++;
        if (nb == ((m_mode == 2'b01) ? 1 : 3)) begin
          m_pixel = (m_mode == 2'b01) ? {16'h0000, mb[0]} : {mb[0], mb[1], mb[2]};
          m_px = 1; nb = 0; busy = 1 + PX_GAP; pcnt++;
          if (pcnt == FP) begin
            m_done = 1; pcnt = 0; in_frame = 0;
          end
        end
      end
    end
    m_ready = (busy == 0);
  end

  int          cyc = 0;
  int          sob_cnt = 0;
  int          done_cnt = 0;
  int          last_done_cyc = -1;
  logic [23:0] got [$];
  int          px_cyc [$];

  always @(negedge clk) begin
    if (started) begin
      cyc++;
      chk("ready", ready, m_ready);
      chk("px_rdy", px_rdy, m_px);
      chk("pixel", out_pixel, m_pixel);
      chk("start_sobel", sobel, m_sobel);
      chk("frame_done", done, m_done);
      if (px_rdy === 1'b1) begin
        got.push_back(out_pixel);
        px_cyc.push_back(cyc);
      end
      if (sobel === 1'b1) sob_cnt++;
      if (done === 1'b1) begin
        done_cnt++;
        last_done_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] s, input bit tog);
    bit ok = 0;
    bit v = 1;
    for (int k = 0; k < 60 && !ok; k++) begin
      valid = v; data = b; sel = s;
      ok = v && m_ready;
      tick();
      if (tog) v = !v;
    end
    valid = 0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: byte %h not accepted within 60 cycles", b);
    end
  endtask

  task automatic idle(input int n);
    valid = 0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    reset = 1; valid = 0;
    tick();
    reset = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  int g0, s0, d0;

  initial begin
    repeat (2) @(posedge clk);
    #2;
    reset = 0;
    chk("rst_ready", ready, 1);
    chk("rst_pixel", out_pixel, 0);
    chk("rst_px_rdy", px_rdy, 0);
    chk("rst_sobel", sobel, 0);
    chk("rst_done", done, 0);

    // mode 00, three bytes back-to-back
    g0 = got.size(); s0 = sob_cnt;
    send(8'h12, 2'b00, 0); send(8'h34, 2'b00, 0); send(8'h56, 2'b00, 0);
    idle(6);
    chk("t1_npx", got.size() - g0, 1);
    chk("t1_pixel", got[g0], 24'h123456);
    chk("t1_sobel", sob_cnt - s0, 1);

    // mode 01, full 4-pixel frame with valid held high
    do_reset();
    g0 = got.size(); d0 = done_cnt;
    send(8'hA5, 2'b01, 0); send(8'h01, 2'b01, 0); send(8'hFF, 2'b01, 0); send(8'h00, 2'b01, 0);
    idle(6);
    chk("t2_npx", got.size() - g0, 4);
    chk("t2_px0", got[g0], 24'h0000A5);
    chk("t2_px1", got[g0+1], 24'h000001);
    chk("t2_px2", got[g0+2], 24'h0000FF);
    chk("t2_px3", got[g0+3], 24'h000000);
    chk("t2_gap01", px_cyc[g0+1] - px_cyc[g0], 4);
    chk("t2_gap23", px_cyc[g0+3] - px_cyc[g0+2], 4);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_done_at_px3", last_done_cyc, px_cyc[g0+3]);
    chk("t2_idle_ready", ready, 1);

    // mode 10 with toggling valid
    do_reset();
    g0 = got.size(); s0 = sob_cnt;
    send(8'hC0, 2'b10, 1); send(8'hFF, 2'b10, 1); send(8'hEE, 2'b10, 1);
    idle(6);
    chk("t3_pixel", got[g0], 24'hC0FFEE);
    chk("t3_no_sobel", sob_cnt - s0, 0);

    // select switched 11 -> 01 after first byte: frame stays 3-byte
    do_reset();
    g0 = got.size(); d0 = done_cnt;
    send(8'h10, 2'b11, 0);
    for (int i = 1; i < 12; i++) send(8'(8'h10 + i), 2'b01, 0);
    idle(6);
    chk("t4_npx", got.size() - g0, 4);
    chk("t4_px0", got[g0], 24'h101112);
    chk("t4_px3", got[g0+3], 24'h191A1B);
    chk("t4_done", done_cnt - d0, 1);
    g0 = got.size(); s0 = sob_cnt;
    send(8'h77, 2'b01, 0);
    idle(6);
    chk("t4_next_1byte", got[g0], 24'h000077);
    chk("t4_next_sobel", sob_cnt - s0, 1);

    // reset mid-pixel
    do_reset();
    send(8'hAA, 2'b00, 0); send(8'hBB, 2'b00, 0);
    g0 = got.size();
    reset = 1;
    tick();
    reset = 0;
    chk("t5_pixel_cleared", out_pixel, 0);
    idle(4);
    chk("t5_no_px", got.size() - g0, 0);
    s0 = sob_cnt;
    send(8'h01, 2'b00, 0); send(8'h02, 2'b00, 0); send(8'h03, 2'b00, 0);
    idle(6);
    chk("t5_pixel", got[g0], 24'h010203);
    chk("t5_sobel", sob_cnt - s0, 1);

    // valid held through EMIT/GAP, byte order preserved
    do_reset();
    g0 = got.size();
    send(8'h31, 2'b00, 0); send(8'h41, 2'b00, 0); send(8'h51, 2'b00, 0);
    send(8'h59, 2'b00, 0); send(8'h26, 2'b00, 0); send(8'h53, 2'b00, 0);
    idle(6);
    chk("t6_px0", got[g0], 24'h314151);
    chk("t6_px1", got[g0+1], 24'h592653);

    // randomized traffic with occasional resets
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 9) < 7);
      data  = 8'($urandom);
      sel   = 2'($urandom);
      reset = ($urandom_range(0, 199) == 0);
      tick();
    end
    reset = 0;
    idle(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
